// File: rtl/st_bus_pkg.sv
// st_bus_pkg: shared constants and FSM encoding for the DT-link transmit path.
//   DEF_BITS_PER_FRAME   bits sent per DT frame
//   DEF_FRAMES_PER_BLOCK frames between tx_int pulses
//   DEF_IDLE_BIT         line level outside slots and on underflow
//   WORD_W               width of one FIFO word (four packed bytes)
//   CNT_W                width of the c4 edge counter within a frame
//   tx_state_e           transmit FSM state encoding
package st_bus_pkg;
    localparam int   DEF_BITS_PER_FRAME   = 32;
    localparam int   DEF_FRAMES_PER_BLOCK = 16;
    localparam logic DEF_IDLE_BIT         = 1'b1;
    localparam int   WORD_W               = 32;
    localparam int   CNT_W                = 10;
    typedef enum logic [1:0] {IDLE, WAIT_F0, SHIFT, GAP} tx_state_e;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock show-ahead FIFO for packed transmit words.
//   clk50    in   clock
//   reset_n  in   asynchronous active-low reset (flushes contents)
//   push     in   write wr_data (accepted when not full, or when popping)
//   wr_data  in   word to write
//   pop      in   drop the head word (ignored when empty)
//   rd_data  out  current head word
//   full     out  DEPTH words stored
//   empty    out  no words stored
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic             clk50,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] count;
    logic do_push, do_pop;
    assign do_pop  = pop & ~empty;
    // a push on full is fine when the head leaves in the same cycle
    assign do_push = push & (~full | do_pop);
    assign full    = count == (AW+1)'(DEPTH);
    assign empty   = count == '0;
    assign rd_data = mem[rd_ptr];
    always_ff @(posedge clk50)
        if (do_push) mem[wr_ptr] <= wr_data;
    always_ff @(posedge clk50 or negedge reset_n)
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= do_push ? wr_ptr + 1'b1 : wr_ptr;
            rd_ptr <= do_pop ? rd_ptr + 1'b1 : rd_ptr;
            count  <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
endmodule

// File: rtl/st_bus_frame_tx.sv
// st_bus_frame_tx: packs STM bytes into words and serialises them onto the DT line.
//   clk50       in   system clock (c4 period >= 4 clk50 periods)
//   reset_n     in   asynchronous active-low reset
//   f0          in   DT frame pulse, active low, async
//   c4          in   DT bit clock, async
//   enable      in   1 = transmit, 0 = idle line after the current frame
//   s_data      in   byte from STM side
//   s_valid     in   s_data valid
//   s_ready     out  byte accepted when s_valid & s_ready
//   clear_flags in   clears underflow / frame_err
//   data_to_dt  out  serial line, bit 0 first, one bit per two c4 edges
//   tx_int      out  one-cycle pulse at the end of each block of frames
//   frame_cnt   out  frame index within the block
//   underflow   out  sticky: a frame started with the FIFO empty
//   frame_err   out  sticky: a frame pulse arrived mid-slot
module st_bus_frame_tx
    import st_bus_pkg::*;
#(
    parameter int   FIFO_DEPTH       = 8,
    parameter int   BITS_PER_FRAME   = DEF_BITS_PER_FRAME,
    parameter int   FRAMES_PER_BLOCK = DEF_FRAMES_PER_BLOCK,
    parameter logic IDLE_BIT         = DEF_IDLE_BIT
) (
    input  logic       clk50,
    input  logic       reset_n,
    input  logic       f0,
    input  logic       c4,
    input  logic       enable,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    output logic       s_ready,
    input  logic       clear_flags,
    output logic       data_to_dt,
    output logic       tx_int,
    output logic [4:0] frame_cnt,
    output logic       underflow,
    output logic       frame_err
);
    localparam logic [CNT_W-1:0] LAST_CNT   = CNT_W'(2*BITS_PER_FRAME-1);
    localparam logic [4:0]       LAST_FRAME = 5'(FRAMES_PER_BLOCK-1);

    logic f0_m, f0_s, c4_m, c4_s, c4_d, c4_rise, frame_pulse;
    always_ff @(posedge clk50 or negedge reset_n)
        if (!reset_n) {f0_m, f0_s, c4_m, c4_s, c4_d} <= 5'b11000;
        else {f0_m, f0_s, c4_m, c4_s, c4_d} <= {f0, f0_m, c4, c4_m, c4_s};
    assign c4_rise     = c4_s & ~c4_d;
    assign frame_pulse = c4_rise & ~f0_s;

    // byte packer: bytes shift in from the top so the first byte lands in bits 7:0
    logic [1:0] pk_cnt;
    logic [23:0] pk_data;
    logic accept, push, pop, full, empty;
    logic [WORD_W-1:0] rd_data;
    assign s_ready = ~(full & (pk_cnt == 2'd3));
    assign accept  = s_valid & s_ready;
    assign push    = accept & (pk_cnt == 2'd3);
    always_ff @(posedge clk50 or negedge reset_n)
        if (!reset_n) begin
            pk_cnt  <= '0;
            pk_data <= '0;
        end else if (accept) begin
            pk_cnt  <= pk_cnt + 1'b1;
            pk_data <= {s_data, pk_data[23:8]};
        end

    sync_fifo #(.WIDTH(WORD_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk50   (clk50),
        .reset_n (reset_n),
        .push    (push),
        .wr_data ({s_data, pk_data}),
        .pop     (pop),
        .rd_data (rd_data),
        .full    (full),
        .empty   (empty)
    );

    logic [CNT_W-1:0] cnt, cnt_nxt;
    assign cnt_nxt = !f0_s ? '0 : (&cnt) ? cnt : cnt + 1'b1;
    always_ff @(posedge clk50 or negedge reset_n)
        if (!reset_n) cnt <= '0;
        else if (c4_rise) cnt <= cnt_nxt;

    tx_state_e state, state_d;
    logic start, shift, done, early;
    always_ff @(posedge clk50 or negedge reset_n)
        if (!reset_n) state <= IDLE;
        else state <= state_d;

    // bits change on edges that make cnt odd so each bit is stable on the even (sampling) edge
    always_comb begin
        state_d = state;
        start   = 1'b0;
        shift   = 1'b0;
        done    = 1'b0;
        early   = 1'b0;
        case (state)
            IDLE: state_d = enable ? WAIT_F0 : IDLE;
            WAIT_F0, GAP: begin
                if (!enable) state_d = IDLE;
                else if (frame_pulse) begin
                    start   = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (frame_pulse) begin
                    early   = 1'b1;
                    start   = enable;
                    state_d = enable ? SHIFT : IDLE;
                end else if (c4_rise && cnt_nxt == LAST_CNT) begin
                    done    = 1'b1;
                    state_d = GAP;
                end else shift = c4_rise & cnt_nxt[0];
            end
            default: state_d = IDLE;
        endcase
    end

    assign pop = start & ~empty;

    logic [WORD_W-1:0] sr;
    always_ff @(posedge clk50 or negedge reset_n)
        if (!reset_n) sr <= {WORD_W{IDLE_BIT}};
        else if (start) sr <= empty ? {WORD_W{IDLE_BIT}} : rd_data;
        else if (shift) sr <= {IDLE_BIT, sr[WORD_W-1:1]};

    assign data_to_dt = (state == SHIFT) ? sr[0] : IDLE_BIT;

    // set events take priority over clear_flags
    always_ff @(posedge clk50 or negedge reset_n)
        if (!reset_n) begin
            frame_cnt <= '0;
            tx_int    <= 1'b0;
            underflow <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            tx_int    <= done & (frame_cnt == LAST_FRAME);
            frame_cnt <= (state == IDLE) ? '0 : !done ? frame_cnt : (frame_cnt == LAST_FRAME) ? '0 : frame_cnt + 1'b1;
            underflow <= (start & empty) | (underflow & ~clear_flags);
            frame_err <= early | (frame_err & ~clear_flags);
        end
endmodule

// File: tb/tb_st_bus_frame_tx.sv
// tb_st_bus_frame_tx: directed bench with a frame-level model of the DT transmit line.
module tb_st_bus_frame_tx;
    localparam int LAST_EDGE = 63;
    localparam int LAST_FRAME = 15;

    logic clk50 = 1'b0, reset_n = 1'b0, f0 = 1'b1, c4 = 1'b0, enable = 1'b0;
    logic s_valid = 1'b0, clear_flags = 1'b0;
    logic [7:0] s_data = 8'h00;
    logic s_ready, data_to_dt, tx_int, underflow, frame_err;
    logic [4:0] frame_cnt;
    int checks = 0, errors = 0;

    always #10 clk50 = ~clk50;

    st_bus_frame_tx dut (
        .clk50       (clk50),
        .reset_n     (reset_n),
        .f0          (f0),
        .c4          (c4),
        .enable      (enable),
        .s_data      (s_data),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .clear_flags (clear_flags),
        .data_to_dt  (data_to_dt),
        .tx_int      (tx_int),
        .frame_cnt   (frame_cnt),
        .underflow   (underflow),
        .frame_err   (frame_err)
    );

    logic [31:0] word_q[$];
    logic [7:0] byte_q[$];
    logic [31:0] m_word = 32'hFFFFFFFF, cap = 32'h0;
    int m_n = -1, m_fc = 0, m_tx = 0, tx_seen = 0;
    logic m_under = 1'b0, m_ferr = 1'b0, tx_prev = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // line level at edge index n of a frame: bit (n+1)/2, idle once the last edge is reached
    function automatic logic exp_line();
        return (m_n < 0 || m_n >= LAST_EDGE) ? 1'b1 : m_word[(m_n+1)/2];
    endfunction

    task automatic model_rise(input bit fl);
        if (fl && enable) begin
            if (m_n >= 0 && m_n < LAST_EDGE) m_ferr = 1'b1;
            if (word_q.size() > 0) m_word = word_q.pop_front();
            else begin
                m_word = 32'hFFFFFFFF;
                m_under = 1'b1;
            end
            m_n = 0;
        end else if (m_n >= 0 && m_n < LAST_EDGE) begin
            m_n++;
            if (m_n == LAST_EDGE) begin
                if (m_fc == LAST_FRAME) begin
                    m_fc = 0;
                    m_tx++;
                end else m_fc++;
            end
        end
    endtask

    task automatic c4_pulse(input bit fl);
        @(negedge clk50);
        f0 = ~fl;
        c4 = 1'b1;
        model_rise(fl);
        repeat (4) @(negedge clk50);
        c4 = 1'b0;
        f0 = 1'b1;
        repeat (4) @(negedge clk50);
    endtask

    task automatic run_frame();
        c4_pulse(1'b1);
        repeat (LAST_EDGE) c4_pulse(1'b0);
    endtask

    task automatic push_byte(input logic [7:0] b);
        int t = 0;
        @(negedge clk50);
        s_data = b;
        s_valid = 1'b1;
        #1;
        while (!s_ready && t < 200) begin
            @(negedge clk50);
            #1;
            t++;
        end
        checks++;
        if (!s_ready) begin
            errors++;
            $display("FAIL push_timeout: s_ready stuck at %b for byte %h", s_ready, b);
            s_valid = 1'b0;
            return;
        end
        @(negedge clk50);
        s_valid = 1'b0;
        byte_q.push_back(b);
        if (byte_q.size() == 4) begin
            word_q.push_back({byte_q[3], byte_q[2], byte_q[1], byte_q[0]});
            byte_q.delete();
        end
    endtask

    task automatic push_word(input logic [31:0] w);
        push_byte(w[7:0]);
        push_byte(w[15:8]);
        push_byte(w[23:16]);
        push_byte(w[31:24]);
    endtask

    task automatic pulse_clear();
        @(negedge clk50);
        clear_flags = 1'b1;
        m_under = 1'b0;
        m_ferr = 1'b0;
        @(negedge clk50);
        clear_flags = 1'b0;
        #1;
    endtask

    always @(negedge c4) begin
        #1;
        if (reset_n) begin
            if (m_n >= 0 && m_n < LAST_EDGE && m_n % 2 == 0) cap[m_n/2] = data_to_dt;
            chk("line", 32'(data_to_dt), 32'(exp_line()));
            chk("frame_cnt", 32'(frame_cnt), 32'(m_fc));
            chk("underflow", 32'(underflow), 32'(m_under));
            chk("frame_err", 32'(frame_err), 32'(m_ferr));
            chk("s_ready", 32'(s_ready), 32'(!(word_q.size() == 8 && byte_q.size() == 3)));
            chk("tx_count", 32'(tx_seen), 32'(m_tx));
        end
    end

    always @(negedge clk50) begin
        if (reset_n && tx_int) begin
            tx_seen++;
            chk("tx_width", 32'(tx_prev), 32'(0));
        end
        tx_prev = tx_int;
    end

    initial begin
        repeat (3) @(negedge clk50);
        chk("rst_line", 32'(data_to_dt), 32'(1));
        chk("rst_tx_int", 32'(tx_int), 32'(0));
        chk("rst_frame_cnt", 32'(frame_cnt), 32'(0));
        chk("rst_underflow", 32'(underflow), 32'(0));
        chk("rst_frame_err", 32'(frame_err), 32'(0));
        chk("rst_s_ready", 32'(s_ready), 32'(1));
        reset_n = 1'b1;
        enable = 1'b1;
        repeat (2) @(negedge clk50);

        push_byte(8'h11);
        push_byte(8'h22);
        push_byte(8'h33);
        push_byte(8'h44);
        run_frame();
        chk("t1_word", cap, 32'h44332211);
        chk("t1_fc", 32'(frame_cnt), 32'(1));

        run_frame();
        chk("t2_word", cap, 32'hFFFFFFFF);
        chk("t2_under", 32'(underflow), 32'(1));
        chk("t2_fc", 32'(frame_cnt), 32'(2));
        pulse_clear();
        chk("t2_clear", 32'(underflow), 32'(0));

        enable = 1'b0;
        m_fc = 0;
        repeat (3) @(negedge clk50);
        #1;
        chk("t3_fc_idle", 32'(frame_cnt), 32'(0));
        enable = 1'b1;
        repeat (2) @(negedge clk50);
        for (int i = 0; i < 16; i++) begin
            push_word({8'hA5, 8'(i), 8'h5A, 8'(~i)});
            run_frame();
            if (i == 14) chk("t3_fc15", 32'(frame_cnt), 32'(15));
        end
        chk("t3_tx", 32'(tx_seen), 32'(1));
        chk("t3_fc_wrap", 32'(frame_cnt), 32'(0));

        push_word(32'h0F0F1234);
        push_word(32'hCAFEBABE);
        c4_pulse(1'b1);
        repeat (19) c4_pulse(1'b0);
        c4_pulse(1'b1);
        chk("t4_ferr", 32'(frame_err), 32'(1));
        chk("t4_fc_hold", 32'(frame_cnt), 32'(0));
        repeat (LAST_EDGE) c4_pulse(1'b0);
        chk("t4_word", cap, 32'hCAFEBABE);
        chk("t4_fc", 32'(frame_cnt), 32'(1));
        pulse_clear();

        for (int i = 0; i < 35; i++) push_byte(8'(i + 1));
        #1;
        chk("t5_ready0", 32'(s_ready), 32'(0));
        c4_pulse(1'b1);
        chk("t5_ready1", 32'(s_ready), 32'(1));
        push_byte(8'd36);
        repeat (LAST_EDGE) c4_pulse(1'b0);
        chk("t5_first", cap, 32'h04030201);
        repeat (8) run_frame();
        chk("t5_last", cap, 32'h24232221);
        chk("t5_no_under", 32'(underflow), 32'(0));
        run_frame();
        chk("t5_drained", 32'(underflow), 32'(1));
        pulse_clear();

        push_word(32'h5A5A0F0F);
        push_word(32'h11112222);
        c4_pulse(1'b1);
        repeat (29) c4_pulse(1'b0);
        chk("t6_pre", 32'(data_to_dt), 32'(0));
        @(negedge clk50);
        #3;
        reset_n = 1'b0;
        word_q.delete();
        byte_q.delete();
        m_n = -1;
        m_fc = 0;
        m_under = 1'b0;
        m_ferr = 1'b0;
        #1;
        chk("t6_line", 32'(data_to_dt), 32'(1));
        chk("t6_ready", 32'(s_ready), 32'(1));
        chk("t6_fc", 32'(frame_cnt), 32'(0));
        repeat (2) @(negedge clk50);
        reset_n = 1'b1;
        repeat (2) @(negedge clk50);
        push_word(32'h600DF00D);
        run_frame();
        chk("t6_word", cap, 32'h600DF00D);
        chk("t6_under", 32'(underflow), 32'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
